imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 25 ++
 rtl/word_packer.sv | 35 +++
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared loader types and constants.
// IMEM_LOADER_CHECKSUM_EN adds the CSUM state to the loader FSM.
package mips_pkg;

   localparam int HDR_W          = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      RUN,
      ERROR
   } loader_state_e;

   // Only the two terminal states refuse upstream bytes.
   function automatic logic accepts_bytes(loader_state_e s);
      return (s != RUN) && (s != ERROR);
   endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles serial bytes, most-significant first, into instruction words and
// flags the byte that completes each word.
module word_packer
   import mips_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_en_i,
   input  logic [7:0]        byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_ready_o
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);

   logic [CNT_W-1:0]  cnt_q;
   // Holds the leading bytes; the final byte completes word_o on the fly so the
   // write can be registered in the very next cycle.
   logic [WORD_W-9:0] shift_q;

   assign word_ready_o = byte_en_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
   assign word_o       = {shift_q, byte_i};

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (byte_en_i) begin
         cnt_q   <= cnt_q + CNT_W'(1);
         shift_q <= {shift_q[WORD_W-17:0], byte_i};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory
// writes, then releases the core. Optional macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   output logic        done,
   output logic        err
);

   loader_state_e     state_q, state_d;
   logic [7:0]        hdr_hi_q;
   logic [HDR_W-1:0]  n_q, idx_q, hdr_n;
   logic              byte_ready_q, imem_we_q, core_rst_q, done_q, err_q;
   logic [31:0]       imem_addr_q, imem_wdata_q;
   logic              xfer, pack_en, word_ready, last_word;
   logic [WORD_W-1:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_e LOAD_END = CSUM;
   logic [7:0] csum_q;
`else
   localparam loader_state_e LOAD_END = RUN;
`endif

   assign xfer      = byte_valid && byte_ready_q;
   assign pack_en   = xfer && (state_q == DATA);
   assign hdr_n     = {hdr_hi_q, byte_data};
   assign last_word = (idx_q == n_q - HDR_W'(1));

   word_packer u_packer (
      .clk_i        (CLK),
      .rst_i        (RST),
      .byte_en_i    (pack_en),
      .byte_i       (byte_data),
      .word_o       (word),
      .word_ready_o (word_ready)
   );

   // NOTE: state_d gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR_HI: if (xfer) state_d = HDR_LO;
         HDR_LO: begin
            if (xfer) begin
               if (32'(hdr_n) > IMEM_DEPTH) state_d = ERROR;
               else if (hdr_n == '0)        state_d = LOAD_END;
               else                         state_d = DATA;
            end
         end
         DATA: if (word_ready && last_word) state_d = LOAD_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: if (xfer) state_d = (byte_data == csum_q) ? RUN : ERROR;
`endif
         default: state_d = state_q;
      endcase
   end

   // Outputs are decoded from the next state so they change with the state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= HDR_HI;
         byte_ready_q <= 1'b1;
         core_rst_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= accepts_bytes(state_d);
         core_rst_q   <= (state_d != RUN);
         done_q       <= (state_d == RUN);
         err_q        <= (state_d == ERROR);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hdr_hi_q     <= '0;
         n_q          <= '0;
         idx_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
      end else begin
         imem_we_q <= word_ready;
         if (xfer && (state_q == HDR_HI)) hdr_hi_q <= byte_data;
         if (xfer && (state_q == HDR_LO)) n_q      <= hdr_n;
         if (word_ready) begin
            imem_addr_q  <= 32'(idx_q);
            imem_wdata_q <= word;
            idx_q        <= idx_q + HDR_W'(1);
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge CLK) begin
      if (RST)                           csum_q <= '0;
      else if (xfer && state_q != CSUM)  csum_q <= csum_q ^ byte_data;
   end
`endif

   assign byte_ready = byte_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst   = core_rst_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expectations follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        CLK        = 1'b0;
   logic        RST        = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data  = 8'h00;
   logic        byte_ready, imem_we, core_rst, done, err;
   logic [31:0] imem_addr, imem_wdata;

   int          checks   = 0;
   int          failures = 0;
   int          wr_cnt   = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];

   imem_loader #(.IMEM_DEPTH(256)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .done       (done),
      .err        (err)
   );

   always #5 CLK = ~CLK;

   // Write log: one entry per cycle that imem_we is high.
   always @(negedge CLK) begin
      if (imem_we) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = imem_addr;
            wr_data[wr_cnt] = imem_wdata;
         end
         wr_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge CLK);
      #1;
      byte_valid = 1'b0;
      byte_data  = 8'hFF;
   endtask

   task automatic send_b(input logic [7:0] b, input int max_gap);
      send_byte(b);
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
   endtask

   task automatic send_hdr(input logic [15:0] n, input int max_gap);
      send_b(n[15:8], max_gap);
      send_b(n[7:0], max_gap);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 3; i >= 0; i--) send_b(w[8*i +: 8], max_gap);
   endtask

   task automatic do_reset();
      RST        = 1'b1;
      byte_valid = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      int base;

      // Reset state
      do_reset();
      check("rst_byte_ready", byte_ready, 1);
      check("rst_imem_we",    imem_we,    0);
      check("rst_imem_addr",  imem_addr,  0);
      check("rst_imem_wdata", imem_wdata, 0);
      check("rst_core_rst",   core_rst,   1);
      check("rst_done",       done,       0);
      check("rst_err",        err,        0);

      // Basic two-word load, back-to-back
      base = wr_cnt;
      send_hdr(16'h0002, 0);
      check("basic_hdr_ready", byte_ready, 1);
      check("basic_hdr_done",  done,       0);
      send_word(32'h2008_0005, 0);
      check("basic_w0_we",    imem_we,    1);
      check("basic_w0_addr",  imem_addr,  0);
      check("basic_w0_wdata", imem_wdata, 32'h2008_0005);
      send_word(32'hAC08_0000, 0);
      check("basic_w1_we",       imem_we,    1);
      check("basic_w1_addr",     imem_addr,  1);
      check("basic_w1_wdata",    imem_wdata, 32'hAC08_0000);
      check("basic_w1_done",     done,       CSUM_EN ? 32'd0 : 32'd1);
      check("basic_w1_core_rst", core_rst,   CSUM_EN ? 32'd1 : 32'd0);
      check("basic_w1_ready",    byte_ready, CSUM_EN ? 32'd1 : 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h8B);
      check("basic_cs_done",     done,     1);
      check("basic_cs_core_rst", core_rst, 0);
      check("basic_cs_err",      err,      0);
`endif
      idle(1);
      check("basic_we_low",     imem_we,    0);
      check("basic_addr_hold",  imem_addr,  1);
      check("basic_wdata_hold", imem_wdata, 32'hAC08_0000);
      send_byte(8'h55);
      check("run_absorb_done",  done,       1);
      check("run_absorb_ready", byte_ready, 0);
      check("basic_wr_count",   wr_cnt - base, 2);
      check("basic_log0_addr",  wr_addr[base],     0);
      check("basic_log0_data",  wr_data[base],     32'h2008_0005);
      check("basic_log1_addr",  wr_addr[base + 1], 1);
      check("basic_log1_data",  wr_data[base + 1], 32'hAC08_0000);

      // Header limits: 256 words fits, 257 words does not
      do_reset();
      send_hdr(16'h0100, 0);
      check("hdr256_err",   err,        0);
      check("hdr256_ready", byte_ready, 1);
      do_reset();
      base = wr_cnt;
      send_hdr(16'h0101, 0);
      check("hdr257_err",      err,        1);
      check("hdr257_ready",    byte_ready, 0);
      check("hdr257_core_rst", core_rst,   1);
      check("hdr257_done",     done,       0);
      send_word(32'h1122_3344, 0);
      check("hdr257_no_write", wr_cnt - base, 0);
      check("hdr257_err_held", err,           1);
      do_reset();
      check("err_exit_ready", byte_ready, 1);
      check("err_exit_err",   err,        0);

      // Three-word load with random idle gaps
      base = wr_cnt;
      idle(2);
      send_hdr(16'h0003, 3);
      send_word(32'h1122_3344, 3);
      send_word(32'h5566_7788, 3);
      send_word(32'h99AA_BBCC, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_b(8'hCF, 3);
`endif
      idle(3);
      check("gap_wr_count", wr_cnt - base, 3);
      check("gap_log0_addr", wr_addr[base],     0);
      check("gap_log0_data", wr_data[base],     32'h1122_3344);
      check("gap_log1_addr", wr_addr[base + 1], 1);
      check("gap_log1_data", wr_data[base + 1], 32'h5566_7788);
      check("gap_log2_addr", wr_addr[base + 2], 2);
      check("gap_log2_data", wr_data[base + 2], 32'h99AA_BBCC);
      check("gap_done",      done,    1);
      check("gap_we_low",    imem_we, 0);

      // Reset two bytes into word 1, coinciding with a valid byte
      do_reset();
      base = wr_cnt;
      send_hdr(16'h0002, 0);
      send_word(32'hDEAD_BEEF, 0);
      send_byte(8'h12);
      send_byte(8'h34);
      RST        = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h56;
      @(posedge CLK);
      #1;
      RST        = 1'b0;
      byte_valid = 1'b0;
      check("midrst_wr_count", wr_cnt - base, 1);
      check("midrst_log_addr", wr_addr[base], 0);
      check("midrst_log_data", wr_data[base], 32'hDEAD_BEEF);
      check("midrst_we",       imem_we,    0);
      check("midrst_ready",    byte_ready, 1);
      check("midrst_done",     done,       0);
      check("midrst_err",      err,        0);
      send_hdr(16'h0001, 0);
      send_word(32'hCAFE_BABE, 0);
      check("fresh_we",    imem_we,    1);
      check("fresh_addr",  imem_addr,  0);
      check("fresh_wdata", imem_wdata, 32'hCAFE_BABE);
      check("fresh_done",  done,       CSUM_EN ? 32'd0 : 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h31);
      check("fresh_cs_done", done, 1);
`endif

      // Zero-length load
      do_reset();
      base = wr_cnt;
      send_hdr(16'h0000, 0);
      check("zero_done",  done,       CSUM_EN ? 32'd0 : 32'd1);
      check("zero_ready", byte_ready, CSUM_EN ? 32'd1 : 32'd0);
      check("zero_err",   err,        0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00);
      check("zero_cs_done",     done,     1);
      check("zero_cs_core_rst", core_rst, 0);
`endif
      idle(1);
      check("zero_no_write", wr_cnt - base, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong checksum on the basic stream
      do_reset();
      send_hdr(16'h0002, 0);
      send_word(32'h2008_0005, 0);
      send_word(32'hAC08_0000, 0);
      send_byte(8'h07);
      check("badcs_err",      err,        1);
      check("badcs_done",     done,       0);
      check("badcs_core_rst", core_rst,   1);
      check("badcs_ready",    byte_ready, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
